pc_generator: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage. It holds the PC register and steps it by one instruction per accepted fetch. It holds the PC across instruction-cache misses and pipeline stalls. It queues branch, jump and exception redirects that arrive while the PC cannot move, and kills wrong-path fetches. It feeds the instruction cache address and the IF/ID pipeline register.

---
 rtl/pc_generator_if.sv | 11 +
 rtl/pc_generator.sv | 63 ++++++
 tb/tb_pc_generator.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_generator_if.sv
// pc_generator_if: fetch-stage control and PC outputs of the program-counter unit.
interface pc_generator_if #(parameter int ADDR_W = 32);
  logic              stall, hit, branch_taken, jump_taken, exc_req;
  logic [ADDR_W-1:0] branch_target, jump_target;
  logic [ADDR_W-1:0] pc_out, pc_next_seq, epc;
  logic              fetch_valid, misalign_err;
  modport master(output stall, hit, branch_taken, branch_target, jump_taken, jump_target, exc_req,
                 input pc_out, pc_next_seq, fetch_valid, epc, misalign_err);
  modport slave(input stall, hit, branch_taken, branch_target, jump_taken, jump_target, exc_req,
                output pc_out, pc_next_seq, fetch_valid, epc, misalign_err);
endinterface

// File: rtl/pc_generator.sv
// pc_generator: fetch PC register with miss/stall hold and a pending-redirect slot.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets to EXC_VECTOR instead of truncating them.
module pc_generator #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 'h80
) (
  input logic            clk,
  input logic            rst_n,
  pc_generator_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, epc_q, pend_tgt, raw_tgt, cur_tgt, pc_n;
  logic [1:0]        pend_pri, cur_pri;
  logic              pend_q, cur_req, bad, redir_eff, adv, use_cur, latch;
  assign cur_req = bus.exc_req | bus.branch_taken | bus.jump_taken;
  assign raw_tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;
`ifdef PC_ALIGN_CHECK_EN
  assign bad = ~bus.exc_req & (bus.branch_taken | bus.jump_taken) & (|(raw_tgt & LOW_MASK));
`else
  assign bad = 1'b0;
`endif
  // Branches and jumps share one pending priority level so a newer one replaces an older one.
  assign cur_pri   = (bus.exc_req | bad) ? 2'd2 : 2'd1;
  assign cur_tgt   = (bus.exc_req | bad) ? EXC_VECTOR : raw_tgt & ~LOW_MASK;
  assign redir_eff = pend_q | cur_req;
  assign adv       = (state != BOOT) & ~bus.stall & (bus.hit | redir_eff);
  assign use_cur   = cur_req & (~pend_q | cur_pri >= pend_pri);
  assign latch     = ~adv & use_cur;
  assign pc_n      = use_cur ? cur_tgt : pend_q ? pend_tgt : bus.pc_next_seq;
  assign bus.pc_out       = pc_q;
  assign bus.pc_next_seq  = pc_q + ADDR_W'(INSTR_BYTES);
  assign bus.epc          = epc_q;
  assign bus.misalign_err = bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_n;
  always_comb
    state_n = state == BOOT ? RUN : bus.stall ? state : (bus.hit | redir_eff) ? RUN : WAIT;
  always_comb
    bus.fetch_valid = (state != BOOT) & bus.hit & ~bus.stall & ~redir_eff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      epc_q    <= '0;
      pend_q   <= 1'b0;
      pend_pri <= '0;
      pend_tgt <= '0;
    end else begin
      if (adv) pc_q <= pc_n;
      if (adv) pend_q <= 1'b0;
      else if (latch) begin
        pend_q   <= 1'b1;
        pend_pri <= cur_pri;
        pend_tgt <= cur_tgt;
      end
      if (bus.exc_req) epc_q <= pc_q;
      else if (bad) epc_q <= raw_tgt;
    end
endmodule

// File: tb/tb_pc_generator.sv
// tb_pc_generator: directed vectors with a queued scoreboard checked on the falling edge.
module tb_pc_generator;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  localparam logic [31:0] P24 = ALN ? 32'h80 : 32'h200;
  localparam logic [31:0] P25 = P24 + 32'h4;
  localparam logic [31:0] E24 = ALN ? 32'h202 : 32'h40;
  typedef struct {string nm; logic [31:0] pc, epc; logic fv, mis;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  exp_t q[$];
  pc_generator_if #(.ADDR_W(32)) bus();
  pc_generator dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pc_out", bus.pc_out, e.pc);
      chk(e.nm, "pc_next_seq", bus.pc_next_seq, e.pc + 32'h4);
      chk(e.nm, "fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
      chk(e.nm, "epc", bus.epc, e.epc);
      chk(e.nm, "misalign_err", 32'(bus.misalign_err), 32'(e.mis));
    end
  task automatic step(input logic rn, s, h, b, input logic [31:0] bt, input logic j,
                      input logic [31:0] jt, input logic e, input logic [31:0] pc,
                      input logic fv, input logic [31:0] ep, input logic mis, input string nm);
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.stall = s; bus.hit = h;
    bus.branch_taken = b; bus.branch_target = bt;
    bus.jump_taken = j; bus.jump_target = jt;
    bus.exc_req = e;
    q.push_back('{nm, pc, ep, fv, mis});
  endtask
  initial begin
    bus.stall = 0; bus.hit = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump_taken = 0; bus.jump_target = 0; bus.exc_req = 0;
    step(0,0,1, 0,0, 0,0, 0, 32'h0,        0, 0, 0, "reset");
    step(1,0,1, 0,0, 0,0, 0, 32'h0,        0, 0, 0, "boot");
    step(1,0,1, 0,0, 0,0, 0, 32'h0,        1, 0, 0, "run0");
    step(1,0,1, 0,0, 0,0, 0, 32'h4,        1, 0, 0, "seq4");
    step(1,0,1, 0,0, 0,0, 0, 32'h8,        1, 0, 0, "seq8");
    step(1,0,1, 0,0, 0,0, 0, 32'hC,        1, 0, 0, "seqC");
    step(1,0,0, 0,0, 0,0, 0, 32'h10,       0, 0, 0, "miss1");
    step(1,0,0, 0,0, 0,0, 0, 32'h10,       0, 0, 0, "miss2");
    step(1,0,0, 0,0, 0,0, 0, 32'h10,       0, 0, 0, "miss3");
    step(1,0,1, 0,0, 0,0, 0, 32'h10,       1, 0, 0, "miss_hit");
    step(1,0,1, 0,0, 0,0, 0, 32'h14,       1, 0, 0, "after_miss");
    step(1,0,1, 0,0, 0,0, 0, 32'h18,       1, 0, 0, "seq18");
    step(1,0,1, 0,0, 0,0, 0, 32'h1C,       1, 0, 0, "seq1C");
    step(1,1,1, 1,32'h100, 0,0, 0, 32'h20, 0, 0, 0, "stall_branch");
    step(1,1,1, 0,0, 1,32'h200, 0, 32'h20, 0, 0, 0, "stall_jump");
    step(1,1,1, 0,0, 0,0, 0, 32'h20,       0, 0, 0, "stall_hold");
    step(1,0,1, 0,0, 0,0, 0, 32'h20,       0, 0, 0, "release_pend");
    step(1,0,1, 0,0, 1,32'h40, 0, 32'h200, 0, 0, 0, "newer_wins");
    step(1,0,1, 1,32'h300, 1,32'h500, 1, 32'h40, 0, 0, 0, "triple_req");
    step(1,0,1, 0,0, 0,0, 0, 32'h80,       1, 32'h40, 0, "exc_applied");
    step(1,0,1, 0,0, 1,32'hFFFF_FFFC, 0, 32'h84, 0, 32'h40, 0, "jump_top");
    step(1,0,1, 0,0, 0,0, 0, 32'hFFFF_FFFC, 1, 32'h40, 0, "at_top");
    step(1,0,1, 0,0, 0,0, 0, 32'h0,        1, 32'h40, 0, "wrap");
    step(1,0,1, 0,0, 1,32'h202, 0, 32'h4,  0, 32'h40, ALN, "misalign");
    step(1,0,1, 0,0, 0,0, 0, P24,          1, E24, 0, "align_target");
    step(1,1,1, 0,0, 0,0, 1, P25,          0, E24, 0, "stall_exc");
    step(1,1,1, 1,32'h400, 0,0, 0, P25,    0, P25, 0, "drop_branch");
    step(1,0,0, 0,0, 0,0, 0, P25,          0, P25, 0, "pend_on_miss");
    step(1,0,1, 0,0, 0,0, 0, 32'h80,       1, P25, 0, "exc_pend_applied");
    step(1,1,1, 0,0, 1,32'h600, 0, 32'h84, 0, P25, 0, "latch_before_rst");
    step(0,0,1, 0,0, 0,0, 0, 32'h0,        0, 0, 0, "async_reset");
    step(1,0,1, 0,0, 0,0, 0, 32'h0,        0, 0, 0, "boot2");
    step(1,0,1, 0,0, 0,0, 0, 32'h0,        1, 0, 0, "pend_discarded");
    step(1,0,1, 0,0, 0,0, 0, 32'h4,        1, 0, 0, "seq4b");
    step(1,0,0, 0,0, 0,0, 0, 32'h8,        0, 0, 0, "miss_b");
    step(1,0,0, 1,32'h1000, 0,0, 0, 32'h8, 0, 0, 0, "redirect_in_miss");
    step(1,0,1, 0,0, 0,0, 0, 32'h1000,     1, 0, 0, "redirect_applied");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
